// File: rtl/seven_segment_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seven_segment_scanner                                         |
// | Purpose  : N-digit multiplexed seven-segment driver. Adds inter-digit    |
// |            blanking, PWM brightness and leading-zero suppression.        |
// |            Display data is double-buffered and committed only at frame   |
// |            boundaries so the display never tears.                        |
// | Ports    : clk, reset      - clock, synchronous active-high reset        |
// |            load            - strobe capturing data_in/digit_enable/      |
// |                              digit_point into the shadow registers       |
// |            data_in         - hex nibbles, digit i = data_in[4i+3:4i]     |
// |            digit_enable    - per-digit lit permission                    |
// |            digit_point     - per-digit decimal point                     |
// |            lz_blank        - live leading-zero suppression control       |
// |            brightness      - PWM duty, 0 = dark, all-ones = full on      |
// |            anode           - active-low digit select (registered)        |
// |            segment         - active-low {DP, g..a} (registered)          |
// |            frame_done      - one-cycle pulse after each frame commit     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    input  logic [NUM_DIGITS-1:0]   digit_point,
    input  logic                    lz_blank,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              segment,
    output logic                    frame_done
);

    localparam int c_slot_w = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int c_idx_w  = $clog2(NUM_DIGITS);

    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(DIGIT_CYCLES - 1);
    localparam logic [c_slot_w-1:0] c_blank_end = c_slot_w'(BLANK_CYCLES);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_DIGITS - 1);

    // Scan counters
    logic [c_slot_w-1:0]     r_slot_cnt;
    logic [c_idx_w-1:0]      r_digit_idx;
    logic [BRIGHT_BITS-1:0]  r_pwm_cnt;

    // Shadow (written by load) and active (displayed) copies of the data
    logic [4*NUM_DIGITS-1:0] r_shadow_data;
    logic [NUM_DIGITS-1:0]   r_shadow_en;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_active_data;
    logic [NUM_DIGITS-1:0]   r_active_en;
    logic [NUM_DIGITS-1:0]   r_active_dp;

    logic                    w_slot_last;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_tail_zero;
    logic                    w_run;
    logic [3:0]              w_sel_nibble;
    logic                    w_sel_en;
    logic                    w_sel_dp;
    logic                    w_sel_tail;
    logic [NUM_DIGITS-1:0]   w_anode_sel;
    logic                    w_suppress;
    logic                    w_pwm_on;
    logic                    w_lit;
    logic [6:0]              w_seg_code;

    assign w_slot_last = (r_slot_cnt == c_slot_last);
    assign w_frame_end = w_slot_last && (r_digit_idx == c_idx_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_slot_last) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == c_idx_last) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    // A load landing exactly on the commit cycle bypasses the shadow so the
    // newest data is shown in the very next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_data <= '0;
            r_shadow_en   <= '0;
            r_shadow_dp   <= '0;
            r_active_data <= '0;
            r_active_en   <= '0;
            r_active_dp   <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= w_frame_end;
            if (load) begin
                r_shadow_data <= data_in;
                r_shadow_en   <= digit_enable;
                r_shadow_dp   <= digit_point;
            end
            if (w_frame_end) begin
                if (load) begin
                    r_active_data <= data_in;
                    r_active_en   <= digit_enable;
                    r_active_dp   <= digit_point;
                end else begin
                    r_active_data <= r_shadow_data;
                    r_active_en   <= r_shadow_en;
                    r_active_dp   <= r_shadow_dp;
                end
            end
        end
    end

    // w_tail_zero[i]: digits i..top are all zero with no decimal point.
    always_comb begin
        w_tail_zero = '0;
        w_run       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run          = w_run && (r_active_data[4*i +: 4] == 4'h0) && !r_active_dp[i];
            w_tail_zero[i] = w_run;
        end
    end

    // Select the attributes of the digit owning the current slot.
    always_comb begin
        w_sel_nibble = 4'h0;
        w_sel_en     = 1'b0;
        w_sel_dp     = 1'b0;
        w_sel_tail   = 1'b0;
        w_anode_sel  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == c_idx_w'(i)) begin
                w_sel_nibble   = r_active_data[4*i +: 4];
                w_sel_en       = r_active_en[i];
                w_sel_dp       = r_active_dp[i];
                w_sel_tail     = w_tail_zero[i];
                w_anode_sel[i] = 1'b0;
            end
        end
    end

    // Digit 0 always shows, so a value of zero still displays '0'.
    assign w_suppress = lz_blank && (r_digit_idx != '0) && w_sel_tail;
    assign w_pwm_on   = (&brightness) || (r_pwm_cnt < brightness);
    assign w_lit      = (r_slot_cnt >= c_blank_end) && w_sel_en && !w_suppress && w_pwm_on;

    always_comb begin
        w_seg_code = 7'b1111111;
        case (w_sel_nibble)
            4'h0:    w_seg_code = 7'b1000000;
            4'h1:    w_seg_code = 7'b1111001;
            4'h2:    w_seg_code = 7'b0100100;
            4'h3:    w_seg_code = 7'b0110000;
            4'h4:    w_seg_code = 7'b0011001;
            4'h5:    w_seg_code = 7'b0010010;
            4'h6:    w_seg_code = 7'b0000010;
            4'h7:    w_seg_code = 7'b1111000;
            4'h8:    w_seg_code = 7'b0000000;
            4'h9:    w_seg_code = 7'b0010000;
            4'hA:    w_seg_code = 7'b0001000;
            4'hB:    w_seg_code = 7'b0000011;
            4'hC:    w_seg_code = 7'b1000110;
            4'hD:    w_seg_code = 7'b0100001;
            4'hE:    w_seg_code = 7'b0000110;
            default: w_seg_code = 7'b0001110;
        endcase
    end

    // Registered pins: anode and segment switch together, no inter-digit glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode   <= '1;
            segment <= 8'hFF;
        end else if (w_lit) begin
            anode   <= w_anode_sel;
            segment <= {~w_sel_dp, w_seg_code};
        end else begin
            anode   <= '1;
            segment <= 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seven_segment_scanner                                      |
// | Purpose  : Scoreboard bench for seven_segment_scanner (4 digits, 8-clock |
// |            slots, 2-clock blanking, 2-bit brightness). Stimulus pushes   |
// |            the hand-computed image of each upcoming frame; a monitor     |
// |            pops one image per frame_done and checks every clock of it.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  digit_enable = 4'h0;
    logic [3:0]  digit_point = 4'h0;
    logic        lz_blank = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seven_segment_scanner #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .BRIGHT_BITS  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .data_in      (data_in),
        .digit_enable (digit_enable),
        .digit_point  (digit_point),
        .lz_blank     (lz_blank),
        .brightness   (brightness),
        .anode        (anode),
        .segment      (segment),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Expected frame image: which digits light, their segment codes
    // {d3,d2,d1,d0}, and the brightness in force during the frame.
    typedef struct {
        int          tag;
        logic [3:0]  lit;
        logic [31:0] segs;
        logic [1:0]  bright;
    } frame_t;

    frame_t exp_q[$];

    function automatic frame_t mk(input int tag, input logic [3:0] lit,
                                  input logic [31:0] segs, input logic [1:0] bright);
        frame_t f;
        f.tag = tag; f.lit = lit; f.segs = segs; f.bright = bright;
        return f;
    endfunction

    // Monitor: sample k after frame_done is digit k/8, slot position k%8.
    initial begin : monitor
        frame_t     cur;
        int         idx;
        int         d;
        int         s;
        logic       on;
        logic [3:0] one;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_fd;
        logic       dig_bad;
        int         bad_s;
        logic [3:0] b_an;  logic [7:0] b_seg;  logic b_fd;
        logic [3:0] w_an;  logic [7:0] w_seg;  logic w_fd;
        idx = -1;
        dig_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                idx = -1;
            end else begin
                if (idx >= 0) begin
                    d = idx / 8;
                    s = idx % 8;
                    on = cur.lit[d] && (s >= 2) &&
                         ((cur.bright == 2'd3) || ((s % 4) < int'(cur.bright)));
                    one   = 4'b0001;
                    e_an  = on ? ~(one << d) : 4'hF;
                    e_seg = on ? cur.segs[8*d +: 8] : 8'hFF;
                    e_fd  = (idx == 31);
                    if (s == 0) dig_bad = 1'b0;
                    if (!dig_bad && (anode !== e_an || segment !== e_seg || frame_done !== e_fd)) begin
                        dig_bad = 1'b1;
                        bad_s = s;
                        b_an = anode; b_seg = segment; b_fd = frame_done;
                        w_an = e_an;  w_seg = e_seg;  w_fd = e_fd;
                    end
                    if (s == 7) begin
                        total++;
                        if (dig_bad) begin
                            bad++;
                            $display("FAIL frame%0d digit%0d slot%0d: got an=%b seg=%b fd=%b, want an=%b seg=%b fd=%b",
                                     cur.tag, d, bad_s, b_an, b_seg, b_fd, w_an, w_seg, w_fd);
                        end
                    end
                    idx++;
                    if (idx == 32) idx = -1;
                end
                if (frame_done) begin
                    if (idx >= 0) begin
                        total++; bad++;
                        $display("FAIL early_frame_done: got pulse at sample %0d, want 32", idx);
                    end
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_frame_done: got pulse, want none queued");
                        idx = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        idx = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 80);
        if (!frame_done) begin
            total++; bad++;
            $display("FAIL wait_frame_done: got no pulse in %0d cycles, want pulse", n);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
        load = 1'b1; data_in = d; digit_enable = en; digit_point = dp;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called on the negedge where reset drops; display must stay blank and
    // the first frame_done must land exactly 32 clocks later.
    task automatic blank_until_fd(input string nm);
        int   n;
        logic seen_lit;
        n = 0;
        seen_lit = 1'b0;
        do begin
            @(negedge clk);
            load = 1'b0;
            n++;
            if (!frame_done && (anode !== 4'hF || segment !== 8'hFF)) seen_lit = 1'b1;
        end while (!frame_done && n < 80);
        chk({nm, "_blank"}, {31'd0, seen_lit}, 32'd0);
        chk({nm, "_fd_cycle"}, n, 32'd32);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("reset_anode", {28'd0, anode}, 32'hF);
        chk("reset_segment", {24'd0, segment}, 32'hFF);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);

        // Release reset and load 1234 on the same clock
        reset = 1'b0;
        load = 1'b1; data_in = 16'h1234; digit_enable = 4'hF; digit_point = 4'h0;
        exp_q.push_back(mk(1, 4'hF, 32'hF9A4B099, 2'd3));
        blank_until_fd("startup");                        // FD1

        // Mid-frame load must not disturb the frame in progress
        repeat (10) @(negedge clk);
        do_load(16'hABCD, 4'hF, 4'h0);
        exp_q.push_back(mk(2, 4'hF, 32'h8883C6A1, 2'd3));
        wait_fd();                                         // FD2

        // Leading-zero suppression
        lz_blank = 1'b1;
        repeat (10) @(negedge clk);
        do_load(16'h0050, 4'hF, 4'h0);
        exp_q.push_back(mk(3, 4'b0011, 32'hFFFF92C0, 2'd3));
        wait_fd();                                         // FD3
        repeat (10) @(negedge clk);
        do_load(16'h0050, 4'hF, 4'h8);
        exp_q.push_back(mk(4, 4'hF, 32'h40C092C0, 2'd3));
        wait_fd();                                         // FD4

        // PWM: brightness 1, then 0
        repeat (10) @(negedge clk);
        do_load(16'h1234, 4'hF, 4'h0);
        exp_q.push_back(mk(5, 4'hF, 32'hF9A4B099, 2'd1));
        wait_fd();                                         // FD5
        brightness = 2'd1;
        repeat (10) @(negedge clk);
        exp_q.push_back(mk(6, 4'hF, 32'hF9A4B099, 2'd0));
        wait_fd();                                         // FD6
        brightness = 2'd0;

        // Shadow gets ABCD, then 9999 lands exactly on the commit cycle
        repeat (10) @(negedge clk);
        do_load(16'hABCD, 4'hF, 4'h0);
        exp_q.push_back(mk(7, 4'hF, 32'h90909090, 2'd3));
        repeat (20) @(negedge clk);
        load = 1'b1; data_in = 16'h9999; digit_enable = 4'hF; digit_point = 4'h0;
        @(negedge clk);                                    // FD7
        load = 1'b0;
        brightness = 2'd3;
        chk("boundary_load_fd", {31'd0, frame_done}, 32'd1);
        exp_q.push_back(mk(8, 4'hF, 32'h90909090, 2'd3));
        wait_fd();                                         // FD8

        // Reset while digit 2 is lit
        repeat (20) @(negedge clk);
        chk("digit2_lit_before_reset", {28'd0, anode}, 32'hB);
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_reset_anode", {28'd0, anode}, 32'hF);
        chk("midframe_reset_segment", {24'd0, segment}, 32'hFF);
        chk("midframe_reset_frame_done", {31'd0, frame_done}, 32'd0);
        exp_q.push_back(mk(9, 4'h0, 32'hFFFFFFFF, 2'd3));
        @(negedge clk);
        reset = 1'b0;
        blank_until_fd("after_reset");                     // FD9: shadow lost, blank frame

        repeat (10) @(negedge clk);
        do_load(16'h1234, 4'hF, 4'h0);
        exp_q.push_back(mk(10, 4'hF, 32'hF9A4B099, 2'd3));
        wait_fd();                                         // FD10
        exp_q.push_back(mk(11, 4'hF, 32'hF9A4B099, 2'd3));
        wait_fd();                                         // FD11
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no completion, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised N-digit multiplexed seven-segment driver. It is the successor to the fixed 4-digit controller and adds the following:
- configurable digit count and scan period
- inter-digit blanking (anti-ghosting)
- PWM brightness
- leading-zero suppression
- double-buffered display data, committed only at frame boundaries so the display never tears

It sits between the UART/datapath logic and the board anode/segment pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (legal range ≥2).
DIGIT_CYCLES, 100000, clocks per digit slot (must exceed BLANK_CYCLES).
BLANK_CYCLES, 1000, dead-time clocks at the start of each slot with all anodes off (≥1).
BRIGHT_BITS, 4, width of the brightness control and of the PWM counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; captures data_in/digit_enable/digit_point into the shadow registers
data_in  in  4*NUM_DIGITS  hex nibbles; digit i = data_in[4i+3:4i]
digit_enable  in  NUM_DIGITS  1 = digit may be lit
digit_point  in  NUM_DIGITS  1 = decimal point lit on digit i
lz_blank  in  1  1 = suppress leading zeros (live control, not buffered)
brightness  in  BRIGHT_BITS  0 = dark, all-ones = full on
anode  out  NUM_DIGITS  active-low digit select
segment  out  8  active-low; [6:0] = g..a, [7] = DP
frame_done  out  1  one-cycle pulse at each frame commit

Behaviour:
- Reset (synchronous, active-high) clears:
  - shadow and active registers to 0
  - slot_cnt, digit_idx and pwm_cnt to 0
  - outputs: anode all-1, segment 8'hFF, frame_done 0
- Counters:
  - slot_cnt counts 0..DIGIT_CYCLES-1 and wraps.
  - On wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
  - pwm_cnt is BRIGHT_BITS wide, free-running +1 every clock, and wraps naturally.
- Frame boundary: the cycle where slot_cnt==DIGIT_CYCLES-1 and digit_idx==NUM_DIGITS-1.
  - active <= shadow on that cycle.
  - frame_done is 1 on the following cycle only.
- Load coinciding with the frame boundary: shadow <= input and active <= input directly, so the newest data wins. Otherwise a load updates shadow only.
- Digit i lit in the current slot only when all of the following hold:
  - digit_idx==i
  - slot_cnt ≥ BLANK_CYCLES
  - active enable[i]==1
  - not leading-zero-suppressed
  - PWM on, where PWM on = (brightness==all-ones) OR (pwm_cnt < brightness)
- Leading-zero suppression (lz_blank=1): digit i>0 is suppressed if nibbles i..NUM_DIGITS-1 are all 0 AND active point bits i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed.
- Outputs are registered with 1-cycle latency from counter state:
  - When lit: anode = one-hot-low on i; segment[6:0] = hex encoding of nibble i; segment[7] = ~point[i].
  - When not lit: anode all-1, segment 8'hFF.
- Hex encoding (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-frame: on the next edge everything returns to reset values, display blank, and shadow data is lost.
- At most one anode bit is low in any cycle. anode and segment never glitch between digits because both are registered.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2, BRIGHT_BITS=2, brightness=3.

1. Reset released; load data 16'h1234, enable 4'hF, point 0 → outputs blank until the first frame_done (cycle 32 after reset). Next frame: digit0 anode 1110 with segment 8'b10011001 ('4') for cycles 3..8 of the slot and blank for cycles 1..2; digits 1..3 show '3','2','1'.
2. Load 16'hABCD mid-frame → the current frame keeps showing 1234 for all remaining slots. The new value appears only after the next frame_done; no mixed frame.
3. Load 16'h0050, lz_blank=1, point=0 → digits 3 and 2 anode stay high. Digit1 shows '5' (0010010); digit0 shows '0'. Repeat with point[3]=1 → digit3 lit with segment 8'b01000000.
4. brightness=1 → in the lit window, anode is low only when pwm_cnt==0 (1 of 4 cycles). brightness=0 → anode all-1 for the entire frame.
5. Load asserted exactly on a frame-boundary cycle with 16'h9999 → the next frame shows 9999 immediately, and frame_done pulses once.
6. reset asserted while digit2 is lit → next cycle anode=4'hF, segment=8'hFF, frame_done=0. After release the display stays blank until the next load plus frame commit.
